rv32i_wb_top: RTL

RV32I_WB_TOP -- requirements
Module: rv32i_wb_top

---
 rtl/rv32i_wb_top_if.sv | 32 +++
 rtl/rv32i_wb_top.sv | 105 ++++++++++
 2 files changed

// File: rtl/rv32i_wb_top_if.sv
// rv32i_wb_top_if: memory-stage inputs, read data and register-file/forwarding outputs of the writeback stage.
// Rev 1.0
`default_nettype none

interface rv32i_wb_top_if;
  logic        wb_en_in;
  logic [31:0] pc_in;
  logic [31:0] iw_in;
  logic [31:0] alu_in;
  logic [4:0]  wb_reg_in;
  logic [1:0]  src_sel_in;
  logic [31:0] memif_rdata;
  logic [31:0] io_rdata;
  logic        regif_wb_enable;
  logic [4:0]  regif_wb_reg;
  logic [31:0] regif_wb_data;
  logic        df_wb_enable;
  logic [4:0]  df_wb_reg;
  logic [31:0] df_wb_data;

  modport master (
    output wb_en_in, pc_in, iw_in, alu_in, wb_reg_in, src_sel_in, memif_rdata, io_rdata,
    input  regif_wb_enable, regif_wb_reg, regif_wb_data, df_wb_enable, df_wb_reg, df_wb_data
  );

  modport slave (
    input  wb_en_in, pc_in, iw_in, alu_in, wb_reg_in, src_sel_in, memif_rdata, io_rdata,
    output regif_wb_enable, regif_wb_reg, regif_wb_data, df_wb_enable, df_wb_reg, df_wb_data
  );
endinterface

`default_nettype wire

// File: rtl/rv32i_wb_top.sv
// rv32i_wb_top: RV32I writeback stage with load alignment; optional retired-instruction
// counter enabled by macro RV32I_WB_INSTRET_EN.  Rev 1.0
`default_nettype none

module rv32i_wb_top #(
  parameter int INSTRET_W = 64
) (
  input  logic clk,
  input  logic reset,
  rv32i_wb_top_if.slave bus
`ifdef RV32I_WB_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  logic        r_wb_en_q;
  logic [31:0] r_pc_q;
  logic [31:0] r_iw_q;
  logic [31:0] r_alu_q;
  logic [4:0]  r_wb_reg_q;
  logic [1:0]  r_src_sel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_en_q   <= 1'b0;
      r_pc_q      <= 32'h0;
      r_iw_q      <= 32'h0;
      r_alu_q     <= 32'h0;
      r_wb_reg_q  <= 5'h0;
      r_src_sel_q <= 2'b00;
    end else begin
      r_wb_en_q   <= bus.wb_en_in;
      r_pc_q      <= bus.pc_in;
      r_iw_q      <= bus.iw_in;
      r_alu_q     <= bus.alu_in;
      r_wb_reg_q  <= bus.wb_reg_in;
      r_src_sel_q <= bus.src_sel_in;
    end
  end

  logic [2:0]  w_funct3;
  logic [31:0] w_raw;
  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wb_data;
  logic        w_wb_enable;

  assign w_funct3  = r_iw_q[14:12];
  assign w_raw     = (r_src_sel_q == 2'b10) ? bus.io_rdata : bus.memif_rdata;
  assign w_shifted = w_raw >> {r_alu_q[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  // Halves ignore alu_q[0]: misaligned halfword addresses round down.
  assign w_half    = r_alu_q[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    w_load = w_raw;
    case (w_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = w_raw;
    endcase
  end

  always_comb begin
    w_wb_data = r_alu_q;
    if (r_src_sel_q == 2'b01 || r_src_sel_q == 2'b10) begin
      w_wb_data = w_load;
    end
  end

  assign w_wb_enable = r_wb_en_q && (r_wb_reg_q != 5'd0);

  assign bus.regif_wb_enable = w_wb_enable;
  assign bus.regif_wb_reg    = r_wb_reg_q;
  assign bus.regif_wb_data   = w_wb_data;
  assign bus.df_wb_enable    = w_wb_enable;
  assign bus.df_wb_reg       = r_wb_reg_q;
  assign bus.df_wb_data      = w_wb_data;

`ifdef RV32I_WB_INSTRET_EN
  logic [INSTRET_W-1:0] r_instret;

  // An all-zero instruction word is a pipeline bubble and does not retire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret <= '0;
    end else if (r_iw_q != 32'h0) begin
      r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  assign instret = r_instret;
`endif

  logic w_unused;
  assign w_unused = ^{r_pc_q, r_iw_q, INSTRET_W[0]};

endmodule

`default_nettype wire
